brush_overlay_mapper: RTL
=========================

Name: brush_overlay_mapper

Overview:
Parametrised, pipelined pixel colour mapper for the paint application. Composites up to N_CURSORS brush/cursor shapes over the incoming canvas pixel stream (iR/iG/iB). Supports four shape modes per cursor, fixed-priority overlap resolution, VSync-driven blinking and optional 50% alpha blend. Sits between the frame-buffer read path and the VGA DAC outputs.

Parameters:
N_CURSORS, 2, number of independent cursor channels (1..8)
COORD_W, 10, coordinate/size width in bits
CH_W, 8, colour channel width in bits
RING_W, 2, outline thickness in pixels for ring mode
BLINK_FRAMES, 30, frames per blink half-period (>=1)
BLEND, 0, 0 = opaque cursor colour; 1 = 50% average of cursor and canvas

Ports:
Clk  in  1  pixel clock
Reset  in  1  asynchronous, active-low reset
DrawX, DrawY  in  COORD_W  current pixel coordinate
pixel_valid  in  1  high during active video
iR, iG, iB  in  CH_W  canvas colour for (DrawX, DrawY)
VSync  in  1  vertical sync, active-low pulse
CurX, CurY  in  N_CURSORS*COORD_W  cursor centres, channel i in slice i
CurS  in  N_CURSORS*COORD_W  cursor size/radius
CurMode  in  N_CURSORS*2  00 filled circle, 01 filled square, 10 ring, 11 crosshair
CurColor  in  N_CURSORS*3*CH_W  per-channel {R,G,B}
CurEn  in  N_CURSORS  channel enable
CurBlink  in  N_CURSORS  channel blinks when set
VGA_R, VGA_G, VGA_B  out  CH_W  composited colour
out_valid  out  1  pixel_valid delayed to match VGA_*
hit  out  1  some cursor covers this output pixel
hit_id  out  max(1,$clog2(N_CURSORS))  index of winning cursor; 0 when hit=0

Behaviour:
- Reset (Reset=0, async): all pipeline regs, VGA_*, out_valid, hit, hit_id = 0; frame counter = 0; blink_phase = 0.
- Latency exactly 3 Clk cycles from DrawX/DrawY/iRGB/pixel_valid to outputs; one pixel accepted every cycle, no stalls.
- Stage 1: register pixel, iRGB, pixel_valid; per channel signed dx = DrawX-CurX, dy = DrawY-CurY (COORD_W+1 bits), register CurS, mode, colour, effective enable. Cursor inputs are sampled with the pixel; mid-frame changes take effect on that pixel.
- Stage 2: per channel d2 = dx^2+dy^2, s2 = S^2 (unsigned, 2*COORD_W+2 bits, no overflow); hit_i:
  circle: d2 <= s2
  square: |dx| <= S and |dy| <= S
  ring: d2 <= s2 and (S < RING_W or d2 > (S-RING_W)^2)
  crosshair: (dx==0 and |dy|<=S) or (dy==0 and |dx|<=S)
  S=0: circle/square/crosshair/ring hit centre pixel only.
- Effective enable = CurEn[i] and not (CurBlink[i] and blink_phase).
- Stage 3: lowest-index hitting channel wins. hit=1, hit_id=i, colour = CurColor[i] (BLEND=0) or (cursor+canvas)>>1 per channel, CH_W+1-bit sum, truncating (BLEND=1). No hit: canvas passed through. Delayed pixel_valid=0: VGA_* = 0, hit = 0, hit_id = 0 regardless.
- Blink: VSync registered once; falling edge (1->0) increments frame counter; at BLINK_FRAMES-1 counter wraps to 0 and blink_phase toggles on the same edge. blink_phase change applies to the next pixel entering stage 1; in-flight pixels unaffected.
- Reset asserted mid-line: outputs drop to 0 immediately; after release the first valid output appears 3 cycles after the first pixel_valid=1 sample.

Test Plan:
- Reset: hold Reset=0 with random inputs -> VGA_*=0, out_valid=0, hit=0; release, pixel_valid=1 at cycle t -> out_valid=1 at t+3.
- Circle boundary: ch0 circle X=100,Y=100,S=5, colour FF/00/00, canvas 10/20/30; pixel (105,100) -> FF/00/00 hit_id=0; (104,104) -> 10/20/30 hit=0 (d2=32>25).
- Priority/modes: ch0 square S=3 at (50,50), ch1 circle S=10 at (50,50); pixel (53,53) -> ch0 colour, hit_id=0; disable ch0 -> (53,53) ch1 colour hit_id=1; ch1 ring RING_W=2 S=10: (50,50) no hit, (59,50) hit.
- Blink: BLINK_FRAMES=2, ch0 CurBlink=1: pixels hit before any VSync; after 2 VSync falling edges -> canvas shown; after 4 -> cursor shown again; CurBlink=0 channel unaffected.
- Blend: BLEND=1, cursor FF/80/00, canvas 01/80/FF, hit -> 80/80/7F.
- Stream/gaps: pixel_valid toggling 1,0,1 with hits -> out_valid 1,0,1 three cycles later, VGA_*=0 on gap; assert Reset mid-stream -> outputs 0 same cycle.

Source files
------------

// File: rtl/brush_overlay_mapper.sv
// -----------------------------------------------------------------------------
// brush_overlay_mapper
//   Three-stage pixel colour mapper. It draws up to N_CURSORS brush or cursor
//   shapes over the canvas pixel stream. Its inputs come from the frame-buffer
//   read path, and its outputs drive the VGA DAC.
//
// Pipeline
//   Stage 1: registers the canvas pixel, pixel_valid and per-cursor attributes.
//            It also registers the signed offsets dx/dy from each cursor centre.
//   Stage 2: tests whether each cursor's shape covers the pixel.
//   Stage 3: resolves priority (lowest index wins) and optionally blends 50%.
//            It also registers the outputs.
//
// Ports
//   Clk, Reset            pixel clock; asynchronous active-low reset
//   DrawX, DrawY          current pixel coordinate
//   pixel_valid           high during active video
//   iR, iG, iB            canvas colour at (DrawX, DrawY)
//   VSync                 active-low vertical sync pulse (drives blinking)
//   CurX/CurY/CurS        per-cursor centre and size (channel i in slice i)
//   CurMode               00 circle, 01 square, 10 ring, 11 crosshair
//   CurColor              per-cursor {R,G,B}
//   CurEn, CurBlink       per-cursor enable and blink select
//   VGA_R/G/B, out_valid  composited colour and delayed pixel_valid
//   hit, hit_id           some cursor covers the pixel / winning cursor index
// -----------------------------------------------------------------------------
module brush_overlay_mapper #(
  parameter int N_CURSORS    = 2,
  parameter int COORD_W      = 10,
  parameter int CH_W         = 8,
  parameter int RING_W       = 2,
  parameter int BLINK_FRAMES = 30,
  parameter int BLEND        = 0,
  localparam int HID_W       = (N_CURSORS > 1) ? $clog2(N_CURSORS) : 1
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [COORD_W-1:0]            DrawX,
  input  logic [COORD_W-1:0]            DrawY,
  input  logic                          pixel_valid,
  input  logic [CH_W-1:0]               iR,
  input  logic [CH_W-1:0]               iG,
  input  logic [CH_W-1:0]               iB,
  input  logic                          VSync,
  input  logic [N_CURSORS*COORD_W-1:0]  CurX,
  input  logic [N_CURSORS*COORD_W-1:0]  CurY,
  input  logic [N_CURSORS*COORD_W-1:0]  CurS,
  input  logic [N_CURSORS*2-1:0]        CurMode,
  input  logic [N_CURSORS*3*CH_W-1:0]   CurColor,
  input  logic [N_CURSORS-1:0]          CurEn,
  input  logic [N_CURSORS-1:0]          CurBlink,
  output logic [CH_W-1:0]               VGA_R,
  output logic [CH_W-1:0]               VGA_G,
  output logic [CH_W-1:0]               VGA_B,
  output logic                          out_valid,
  output logic                          hit,
  output logic [HID_W-1:0]              hit_id
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int D2_W  = 2 * COORD_W + 2;
  localparam int RGB_W = 3 * CH_W;

  // ---------------------------------------------------------------------------
  // Shape test. dx/dy are exact signed differences, so |dx| needs COORD_W+1
  // bits. The squared terms fit in D2_W bits without overflow.
  // ---------------------------------------------------------------------------
  function automatic logic shape_hit(input logic signed [COORD_W:0] dx,
                                     input logic signed [COORD_W:0] dy,
                                     input logic [COORD_W-1:0]       s,
                                     input logic [1:0]               mode);
    logic [COORD_W:0]   adx;
    logic [COORD_W:0]   ady;
    logic [COORD_W:0]   s_ext;
    logic [COORD_W-1:0] inner;
    logic [D2_W-1:0]    d2;
    logic [D2_W-1:0]    s2;
    logic [D2_W-1:0]    r2;
    logic               res;
    adx   = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
    ady   = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
    s_ext = {1'b0, s};
    d2    = D2_W'(adx) * D2_W'(adx) + D2_W'(ady) * D2_W'(ady);
    s2    = D2_W'(s) * D2_W'(s);
    // The inner radius is only meaningful when S >= RING_W; the ring test
    // below ignores r2 otherwise.
    inner = s - COORD_W'(RING_W);
    r2    = D2_W'(inner) * D2_W'(inner);
    case (mode)
      2'b00:   res = (d2 <= s2);
      2'b01:   res = (adx <= s_ext) && (ady <= s_ext);
      2'b10:   res = (d2 <= s2) && ((s < COORD_W'(RING_W)) || (d2 > r2));
      2'b11:   res = ((dx == '0) && (ady <= s_ext)) || ((dy == '0) && (adx <= s_ext));
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Blink control
  // ---------------------------------------------------------------------------
  logic             vsync_q;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  // Frame counter: advance on each VSync falling edge, toggle phase on wrap.
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (vsync_q && !VSync) begin
      if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d   = frame_cnt_q + CNT_W'(1);
        blink_phase_d = blink_phase_q;
      end
    end else begin
      frame_cnt_d   = frame_cnt_q;
      blink_phase_d = blink_phase_q;
    end
  end

  // Blink state registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      vsync_q       <= 1'b0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      vsync_q       <= VSync;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1
  // ---------------------------------------------------------------------------
  logic                     s1_valid_q;
  logic [RGB_W-1:0]         s1_rgb_q;
  logic signed [COORD_W:0]  s1_dx_q [N_CURSORS];
  logic signed [COORD_W:0]  s1_dy_q [N_CURSORS];
  logic signed [COORD_W:0]  s1_dx_d [N_CURSORS];
  logic signed [COORD_W:0]  s1_dy_d [N_CURSORS];
  logic [COORD_W-1:0]       s1_s_q  [N_CURSORS];
  logic [1:0]               s1_mode_q [N_CURSORS];
  logic [RGB_W-1:0]         s1_col_q [N_CURSORS];
  logic [N_CURSORS-1:0]     s1_en_q, s1_en_d;

  // Offsets from each cursor centre and blink-gated enables.
  always_comb begin
    for (int i = 0; i < N_CURSORS; i++) begin
      s1_dx_d[i] = $signed({1'b0, DrawX}) - $signed({1'b0, CurX[i*COORD_W +: COORD_W]});
      s1_dy_d[i] = $signed({1'b0, DrawY}) - $signed({1'b0, CurY[i*COORD_W +: COORD_W]});
    end
    s1_en_d = CurEn & ~(CurBlink & {N_CURSORS{blink_phase_q}});
  end

  // Stage 1 registers: pixel plus per-cursor attributes, sampled together.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1_valid_q <= 1'b0;
      s1_rgb_q   <= '0;
      s1_en_q    <= '0;
      for (int i = 0; i < N_CURSORS; i++) begin
        s1_dx_q[i]   <= '0;
        s1_dy_q[i]   <= '0;
        s1_s_q[i]    <= '0;
        s1_mode_q[i] <= '0;
        s1_col_q[i]  <= '0;
      end
    end else begin
      s1_valid_q <= pixel_valid;
      s1_rgb_q   <= {iR, iG, iB};
      s1_en_q    <= s1_en_d;
      for (int i = 0; i < N_CURSORS; i++) begin
        s1_dx_q[i]   <= s1_dx_d[i];
        s1_dy_q[i]   <= s1_dy_d[i];
        s1_s_q[i]    <= CurS[i*COORD_W +: COORD_W];
        s1_mode_q[i] <= CurMode[i*2 +: 2];
        s1_col_q[i]  <= CurColor[i*RGB_W +: RGB_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2
  // ---------------------------------------------------------------------------
  logic                 s2_valid_q;
  logic [RGB_W-1:0]     s2_rgb_q;
  logic [RGB_W-1:0]     s2_col_q [N_CURSORS];
  logic [N_CURSORS-1:0] s2_hit_q, s2_hit_d;

  // Per-channel coverage test.
  always_comb begin
    for (int i = 0; i < N_CURSORS; i++) begin
      s2_hit_d[i] = s1_en_q[i] & shape_hit(s1_dx_q[i], s1_dy_q[i], s1_s_q[i], s1_mode_q[i]);
    end
  end

  // Stage 2 registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s2_valid_q <= 1'b0;
      s2_rgb_q   <= '0;
      s2_hit_q   <= '0;
      for (int i = 0; i < N_CURSORS; i++) begin
        s2_col_q[i] <= '0;
      end
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_rgb_q   <= s1_rgb_q;
      s2_hit_q   <= s2_hit_d;
      for (int i = 0; i < N_CURSORS; i++) begin
        s2_col_q[i] <= s1_col_q[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3
  // ---------------------------------------------------------------------------
  logic             found_s;
  logic [HID_W-1:0] win_id_s;
  logic [RGB_W-1:0] win_col_s;
  logic [RGB_W-1:0] mix_col_s;
  logic [CH_W:0]    sum_s;
  logic [RGB_W-1:0] rgb_d, rgb_q;
  logic             hit_d, hit_q;
  logic [HID_W-1:0] hid_d, hid_q;
  logic             valid_q;

  // Priority resolve (lowest index wins), optional blend and blanking.
  always_comb begin
    found_s   = 1'b0;
    win_id_s  = '0;
    win_col_s = s2_rgb_q;
    mix_col_s = '0;
    sum_s     = '0;
    rgb_d     = '0;
    hit_d     = 1'b0;
    hid_d     = '0;
    for (int i = 0; i < N_CURSORS; i++) begin
      if (s2_hit_q[i] && !found_s) begin
        found_s   = 1'b1;
        win_id_s  = HID_W'(i);
        win_col_s = s2_col_q[i];
      end else begin
        found_s   = found_s;
      end
    end
    // A 9-bit sum keeps the carry; dropping bit 0 halves with truncation.
    for (int c = 0; c < 3; c++) begin
      sum_s = {1'b0, win_col_s[c*CH_W +: CH_W]} + {1'b0, s2_rgb_q[c*CH_W +: CH_W]};
      mix_col_s[c*CH_W +: CH_W] = sum_s[CH_W:1];
    end
    if (!s2_valid_q) begin
      rgb_d = '0;
      hit_d = 1'b0;
      hid_d = '0;
    end else if (found_s) begin
      rgb_d = (BLEND != 0) ? mix_col_s : win_col_s;
      hit_d = 1'b1;
      hid_d = win_id_s;
    end else begin
      rgb_d = s2_rgb_q;
      hit_d = 1'b0;
      hid_d = '0;
    end
  end

  // Output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rgb_q   <= '0;
      hit_q   <= 1'b0;
      hid_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      hit_q   <= hit_d;
      hid_q   <= hid_d;
      valid_q <= s2_valid_q;
    end
  end

  assign VGA_R     = rgb_q[2*CH_W +: CH_W];
  assign VGA_G     = rgb_q[CH_W +: CH_W];
  assign VGA_B     = rgb_q[0 +: CH_W];
  assign out_valid = valid_q;
  assign hit       = hit_q;
  assign hit_id    = hid_q;

endmodule
